regfile_trace_unit: RTL
=======================

# regfile_trace_unit

Hardware producer for processor writeback trace and register-dump records. It snoops the regfile write port, stamps each committed write with a cycle count, and buffers it in a FIFO. On request it takes over regfile read port A and scans r0–r31 into the same FIFO. A valid/ready consumer (UART bridge, logic analyzer, host link) drains the records. It sits beside `processor`/`regfile` in the wrapper, and the read-port-A mux is driven by `dump_sel`.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `CYCLE_W`, 16: cycle-stamp width.

- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: capture/count enable.
- `rwe` in 1: snooped regfile write enable.
- `rd` in 5: snooped write register.
- `rData` in 32: snooped write data.
- `dump_start` in 1: single-cycle dump request.
- `regA` in 32: regfile read-port-A data; combinational from `dump_rs`.
- `dump_busy` out 1: dump in progress.
- `dump_sel` out 1: when 1, wrapper muxes `dump_rs` onto `ctrl_readRegA`.
- `dump_rs` out 5: register index under scan.
- `rec_valid` out 1: FIFO head valid.
- `rec_ready` in 1: consumer accepts head.
- `rec_kind` out 1: 0 = write event, 1 = dump record.
- `rec_cycle` out CYCLE_W: cycle stamp.
- `rec_reg` out 5: register number.
- `rec_data` out 32: register value.
- `overflow` out 1: sticky; at least one event dropped.
- `dropped` out 16: dropped-event count, saturating.

## Operation
- **Reset values:** state IDLE, FIFO empty, cycle counter 0, `dump_busy`=0, `dump_sel`=0, `dump_rs`=0, `rec_valid`=0, `rec_*` fields 0, `overflow`=0, `dropped`=0.
- **Cycle counter:** increments on each edge with `enable`=1 and state IDLE. Holds otherwise. Wraps modulo 2^CYCLE_W.
- **Capture** (IDLE only): on an edge with `enable && rwe && rd!=0`, push {0, counter, rd, rData}. The stamp is the counter value before that edge's increment, so the first enabled write after reset is stamped 0. Writes with `rd`=0 are never recorded.
- **Capture when FIFO full:** the event is dropped, `overflow` is set, and `dropped` increments, saturating at 16'hFFFF.
- **Full is based on the occupancy before the edge:** a push while full is rejected even if a pop occurs on the same edge.
- **FIFO behaviour:** show-ahead; `rec_*` always show the head. A pop happens on an edge with `rec_valid && rec_ready`. Simultaneous push and pop when not full keeps occupancy unchanged. Records leave in push order.
- **FSM states:**
  - IDLE: `dump_start`=1 → SCAN with idx=0.
  - SCAN: `dump_sel`=1, `dump_busy`=1, `dump_rs`=idx.
    - If FIFO not full: push {1, frozen counter, idx, regA}, then idx+1.
    - If FIFO full: hold idx; no record is lost.
    - After pushing idx=31 → IDLE.
- **During SCAN:** snooped writes are ignored and are not counted in `dropped`. `dump_start` is ignored.
- **Reset mid-dump:** scan aborts and the FIFO is emptied at that edge.

## Timing
- Capture latency: event at edge N → `rec_valid`=1 after edge N if FIFO was empty.
- `dump_busy`/`dump_sel` rise after the edge sampling `dump_start`. They fall after the edge that pushes r31.
- With `rec_ready`=1 throughout and an initially empty FIFO, SCAN lasts exactly 32 cycles.
- `regA` is sampled on the same edge where `dump_rs` has been stable for the whole cycle; no extra wait state.
- While `rec_valid && !rec_ready`, all `rec_*` are held stable.
- Counter wrap: stamp (2^CYCLE_W)−1 is followed by stamp 0.

## Test plan
- **Single capture:** reset, `enable`=1, `rwe`=1 `rd`=5 `rData`=42 at the first edge → one record: kind 0, cycle 0, reg 5, data 42; `rec_valid` high the next cycle.
- **r0 filter:** `rwe`=1 `rd`=0 `rData`=7 → no record; `rec_valid` stays 0; `dropped`=0.
- **Overflow:** `rec_ready`=0, 18 consecutive writes r1..r18 with DEPTH=16 → 16 records held, `overflow`=1, `dropped`=2. Then `rec_ready`=1 drains r1..r16 in order with stamps 0..15.
- **Full dump:** regfile model returns 3×idx, `rec_ready`=1, pulse `dump_start` → 32 kind-1 records for reg 0..31 with data 0,3,…,93; `dump_sel` high for exactly 32 cycles.
- **Dump backpressure:** `rec_ready`=0 during dump → scan stalls with `dump_rs`=16 and FIFO full; `dropped` unchanged. Releasing ready completes all 32 records with none missing.
- **Reset mid-dump:** assert `reset` when `dump_rs`=10 → after that edge `dump_busy`=0, `dump_sel`=0, `rec_valid`=0, `overflow`=0.

Source files
------------

// File: rtl/regfile_trace_unit_if.sv
// Record stream from the trace unit to its consumer (UART bridge, logic analyzer, host link).
// Valid/ready handshake; the producer keeps every payload field stable while valid is high and ready is low.
interface regfile_trace_unit_if #(
    parameter int CYCLE_W = 16
);
    logic               rec_valid;
    logic               rec_ready;
    logic               rec_kind;
    logic [CYCLE_W-1:0] rec_cycle;
    logic [4:0]         rec_reg;
    logic [31:0]        rec_data;

    modport master (
        output rec_valid,
        output rec_kind,
        output rec_cycle,
        output rec_reg,
        output rec_data,
        input  rec_ready
    );

    modport slave (
        input  rec_valid,
        input  rec_kind,
        input  rec_cycle,
        input  rec_reg,
        input  rec_data,
        output rec_ready
    );
endinterface

// File: rtl/regfile_trace_unit.sv
// Writeback trace and register-dump producer: snoops regfile writes, stamps them with a cycle count,
// scans r0-r31 through read port A on request, and queues all records in one show-ahead FIFO.
module regfile_trace_unit #(
    parameter int DEPTH   = 16,
    parameter int CYCLE_W = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        rwe,
    input  logic [4:0]  rd,
    input  logic [31:0] rData,
    input  logic        dump_start,
    input  logic [31:0] regA,
    output logic        dump_busy,
    output logic        dump_sel,
    output logic [4:0]  dump_rs,
    regfile_trace_unit_if.master rec,
    output logic        overflow,
    output logic [15:0] dropped
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t state;
    state_t state_next;
    logic [4:0] idx;
    logic [4:0] idx_next;

    logic [CYCLE_W-1:0] cycle_count;

    logic               mem_kind  [DEPTH];
    logic [CYCLE_W-1:0] mem_cycle [DEPTH];
    logic [4:0]         mem_reg   [DEPTH];
    logic [31:0]        mem_data  [DEPTH];

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;

    logic fifo_full;
    logic fifo_empty;
    logic capture_req;
    logic scan_req;
    logic push;
    logic pop;
    logic drop;

    logic               push_kind;
    logic [CYCLE_W-1:0] push_cycle;
    logic [4:0]         push_reg;
    logic [31:0]        push_data;

    // Full is judged on occupancy before the edge, so a same-edge pop never makes room for a push.
    assign fifo_full  = (count == (AW+1)'(DEPTH));
    assign fifo_empty = (count == '0);

    assign capture_req = (state == IDLE) && enable && rwe && (rd != 5'd0);
    assign scan_req    = (state == SCAN);
    assign push        = (capture_req || scan_req) && !fifo_full;
    assign drop        = capture_req && fifo_full;
    assign pop         = !fifo_empty && rec.rec_ready;

    assign push_kind  = scan_req;
    assign push_cycle = cycle_count;
    assign push_reg   = scan_req ? idx  : rd;
    assign push_data  = scan_req ? regA : rData;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            idx   <= 5'd0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // A full FIFO stalls the scan on the current index so no dump record is ever lost.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            IDLE: begin
                if (dump_start) begin
                    state_next = SCAN;
                    idx_next   = 5'd0;
                end
            end
            SCAN: begin
                if (!fifo_full) begin
                    if (idx == 5'd31) begin
                        state_next = IDLE;
                        idx_next   = 5'd0;
                    end else begin
                        idx_next = idx + 5'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = 5'd0;
            end
        endcase
    end

    assign dump_busy = (state == SCAN);
    assign dump_sel  = (state == SCAN);
    assign dump_rs   = idx;

    // The stamp freezes during a scan so every dump record carries the cycle the dump began.
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_count <= '0;
        end else if (enable && (state == IDLE)) begin
            cycle_count <= cycle_count + CYCLE_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_kind[wr_ptr]  <= push_kind;
            mem_cycle[wr_ptr] <= push_cycle;
            mem_reg[wr_ptr]   <= push_reg;
            mem_data[wr_ptr]  <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            overflow <= 1'b0;
            dropped  <= 16'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (dropped != 16'hFFFF) begin
                dropped <= dropped + 16'd1;
            end
        end
    end

    // Fields read as zero when empty so stale storage never leaks out after reset.
    always_comb begin
        rec.rec_valid = !fifo_empty;
        rec.rec_kind  = 1'b0;
        rec.rec_cycle = '0;
        rec.rec_reg   = 5'd0;
        rec.rec_data  = 32'd0;
        if (!fifo_empty) begin
            rec.rec_kind  = mem_kind[rd_ptr];
            rec.rec_cycle = mem_cycle[rd_ptr];
            rec.rec_reg   = mem_reg[rd_ptr];
            rec.rec_data  = mem_data[rd_ptr];
        end
    end

endmodule
